// File: rtl/mode_counter.sv
// mode_counter: loadable up/down counter with programmable upper limit, prescaler and three
// count modes (wrap, saturate, one-shot). A step taken while sitting on the boundary is a
// "boundary event": it pulses tc_o for the following cycle and sets the sticky ovf_o flag.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_n       asynchronous active-low reset
//   enable_i    counting enable, gates the prescaler and steps
//   load_i      synchronous load of data_i (works regardless of enable_i)
//   data_i      load value
//   up_i        1 = count up, 0 = count down
//   mode_i      00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   limit_i     upper boundary value
//   prescale_i  a step is issued every prescale_i+1 enabled cycles
//   clr_ovf_i   clear sticky ovf_o (a simultaneous set wins)
//   count_o     current count
//   tc_o        one-cycle terminal-count pulse
//   ovf_o       sticky boundary-event flag
//   busy_o      one-shot run in progress
module mode_counter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  up_i,
    input  logic [1:0]            mode_i,
    input  logic [WIDTH-1:0]      limit_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  clr_ovf_i,
    output logic [WIDTH-1:0]      count_o,
    output logic                  tc_o,
    output logic                  ovf_o,
    output logic                  busy_o
);

    localparam logic [1:0] ModeSat     = 2'b01;
    localparam logic [1:0] ModeOneShot = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic                  tc_q, tc_d;
    logic                  ovf_q, ovf_d;

    logic                  step;
    logic                  at_bound;
    logic                  evt;
    logic [WIDTH-1:0]      count_step;

    always_comb begin
        step       = enable_i && (p_q == prescale_i);
        // Up boundary uses >= so a loaded value above the limit is caught on the next step.
        at_bound   = up_i ? (count_q >= limit_i) : (count_q == '0);
        count_step = up_i ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end

    always_comb begin
        count_d = count_q;
        p_d     = p_q;
        state_d = state_q;
        evt     = 1'b0;

        // Leaving one-shot mode abandons any run.
        if (mode_i != ModeOneShot) begin
            state_d = StIdle;
        end

        if (load_i) begin
            count_d = data_i;
            p_d     = '0;
            state_d = (mode_i == ModeOneShot) ? StRun : StIdle;
        end else begin
            if (enable_i) begin
                p_d = step ? '0 : p_q + PRESCALE_W'(1);
            end
            if (step) begin
                case (mode_i)
                    ModeSat: begin
                        if (at_bound) begin
                            evt = 1'b1;
                        end else begin
                            count_d = count_step;
                        end
                    end
                    ModeOneShot: begin
                        // Steps outside a run are ignored entirely, including boundary events.
                        if (state_q == StRun) begin
                            if (at_bound) begin
                                evt     = 1'b1;
                                state_d = StDone;
                            end else begin
                                count_d = count_step;
                            end
                        end
                    end
                    default: begin
                        if (at_bound) begin
                            evt     = 1'b1;
                            count_d = up_i ? '0 : limit_i;
                        end else begin
                            count_d = count_step;
                        end
                    end
                endcase
            end
        end

        tc_d  = evt;
        ovf_d = evt | (ovf_q & ~clr_ovf_i);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            p_q     <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            p_q     <= p_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign ovf_o   = ovf_q;
    assign busy_o  = (state_q == StRun);

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter: a table of per-cycle input/expected-output records applied
// one clock each, followed by a hand-written asynchronous-reset sequence.
module tb_mode_counter;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable, load, up, clr_ovf;
    logic [W-1:0]  data, limit;
    logic [1:0]    mode;
    logic [PW-1:0] prescale;
    logic [W-1:0]  count;
    logic          tc, ovf, busy;

    mode_counter #(
        .WIDTH     (W),
        .PRESCALE_W(PW)
    ) dut (
        .clk_i     (clk),
        .rst_n     (rst_n),
        .enable_i  (enable),
        .load_i    (load),
        .data_i    (data),
        .up_i      (up),
        .mode_i    (mode),
        .limit_i   (limit),
        .prescale_i(prescale),
        .clr_ovf_i (clr_ovf),
        .count_o   (count),
        .tc_o      (tc),
        .ovf_o     (ovf),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          en;
        logic          ld;
        logic [W-1:0]  dat;
        logic          up;
        logic [1:0]    md;
        logic [W-1:0]  lim;
        logic [PW-1:0] pre;
        logic          clr;
        logic [W-1:0]  e_count;
        logic          e_tc;
        logic          e_ovf;
        logic          e_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void add(string name, logic en, logic ld, logic [W-1:0] dat, logic u,
                                logic [1:0] md, logic [W-1:0] lim, logic [PW-1:0] pre,
                                logic clr, logic [W-1:0] ec, logic et, logic eo, logic eb);
        vec_t v;
        v.name = name; v.en = en; v.ld = ld; v.dat = dat; v.up = u; v.md = md; v.lim = lim;
        v.pre = pre; v.clr = clr; v.e_count = ec; v.e_tc = et; v.e_ovf = eo; v.e_busy = eb;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(string name, logic [W-1:0] ec, logic et, logic eo, logic eb);
        chk({name, ".count"}, 32'(count), 32'(ec));
        chk({name, ".tc"},    32'(tc),    32'(et));
        chk({name, ".ovf"},   32'(ovf),   32'(eo));
        chk({name, ".busy"},  32'(busy),  32'(eb));
    endtask

    initial begin
        //   name     en ld dat  up md     lim  pre clr  cnt tc ovf busy
        // Wrap up to 5.
        add("wrap1",  1, 0, 0,   1, 2'b00, 5,   0,  0,   1,  0, 0, 0);
        add("wrap2",  1, 0, 0,   1, 2'b00, 5,   0,  0,   2,  0, 0, 0);
        add("wrap3",  1, 0, 0,   1, 2'b00, 5,   0,  0,   3,  0, 0, 0);
        add("wrap4",  1, 0, 0,   1, 2'b00, 5,   0,  0,   4,  0, 0, 0);
        add("wrap5",  1, 0, 0,   1, 2'b00, 5,   0,  0,   5,  0, 0, 0);
        add("wrap0",  1, 0, 0,   1, 2'b00, 5,   0,  0,   0,  1, 1, 0);
        add("wrap1b", 1, 0, 0,   1, 2'b00, 5,   0,  0,   1,  0, 1, 0);
        // Saturate down from 2.
        add("satld",  1, 1, 2,   0, 2'b01, 5,   0,  0,   2,  0, 1, 0);
        add("sat1",   1, 0, 0,   0, 2'b01, 5,   0,  0,   1,  0, 1, 0);
        add("sat0",   1, 0, 0,   0, 2'b01, 5,   0,  0,   0,  0, 1, 0);
        add("sath1",  1, 0, 0,   0, 2'b01, 5,   0,  0,   0,  1, 1, 0);
        add("sath2",  1, 0, 0,   0, 2'b01, 5,   0,  0,   0,  1, 1, 0);
        add("setclr", 1, 0, 0,   0, 2'b01, 5,   0,  1,   0,  1, 1, 0);
        add("clr",    0, 0, 0,   0, 2'b01, 5,   0,  1,   0,  0, 0, 0);
        // One-shot up to 3, then rearm.
        add("osld",   1, 1, 0,   1, 2'b10, 3,   0,  0,   0,  0, 0, 1);
        add("os1",    1, 0, 0,   1, 2'b10, 3,   0,  0,   1,  0, 0, 1);
        add("os2",    1, 0, 0,   1, 2'b10, 3,   0,  0,   2,  0, 0, 1);
        add("os3",    1, 0, 0,   1, 2'b10, 3,   0,  0,   3,  0, 0, 1);
        add("osend",  1, 0, 0,   1, 2'b10, 3,   0,  0,   3,  1, 1, 0);
        add("osdone", 1, 0, 0,   1, 2'b10, 3,   0,  0,   3,  0, 1, 0);
        add("osrarm", 1, 1, 1,   1, 2'b10, 3,   0,  0,   1,  0, 1, 1);
        add("osr2",   1, 0, 0,   1, 2'b10, 3,   0,  0,   2,  0, 1, 1);
        // Prescale 3: step every 4 enabled cycles.
        add("psld",   1, 1, 10,  1, 2'b00, 200, 3,  1,   10, 0, 0, 0);
        add("ps1",    1, 0, 0,   1, 2'b00, 200, 3,  0,   10, 0, 0, 0);
        add("ps2",    1, 0, 0,   1, 2'b00, 200, 3,  0,   10, 0, 0, 0);
        add("ps3",    1, 0, 0,   1, 2'b00, 200, 3,  0,   10, 0, 0, 0);
        add("ps4",    1, 0, 0,   1, 2'b00, 200, 3,  0,   11, 0, 0, 0);
        add("ps5",    1, 0, 0,   1, 2'b00, 200, 3,  0,   11, 0, 0, 0);
        add("psoff1", 0, 0, 0,   1, 2'b00, 200, 3,  0,   11, 0, 0, 0);
        add("psoff2", 0, 0, 0,   1, 2'b00, 200, 3,  0,   11, 0, 0, 0);
        add("ps6",    1, 0, 0,   1, 2'b00, 200, 3,  0,   11, 0, 0, 0);
        add("ps7",    1, 0, 0,   1, 2'b00, 200, 3,  0,   11, 0, 0, 0);
        add("ps8",    1, 0, 0,   1, 2'b00, 200, 3,  0,   12, 0, 0, 0);
        add("ps9",    1, 0, 0,   1, 2'b00, 200, 3,  0,   12, 0, 0, 0);
        add("ps10",   1, 0, 0,   1, 2'b00, 200, 3,  0,   12, 0, 0, 0);
        add("psld2",  1, 1, 50,  1, 2'b00, 200, 3,  0,   50, 0, 0, 0);
        add("ps11",   1, 0, 0,   1, 2'b00, 200, 3,  0,   50, 0, 0, 0);
        add("ps12",   1, 0, 0,   1, 2'b00, 200, 3,  0,   50, 0, 0, 0);
        add("ps13",   1, 0, 0,   1, 2'b00, 200, 3,  0,   50, 0, 0, 0);
        add("ps14",   1, 0, 0,   1, 2'b00, 200, 3,  0,   51, 0, 0, 0);
        // Data above limit, down wrap to limit, limit 0, mode 11 as wrap.
        add("hild",   1, 1, 200, 1, 2'b00, 4,   0,  0,   200, 0, 0, 0);
        add("hiup",   1, 0, 0,   1, 2'b00, 4,   0,  0,   0,  1, 1, 0);
        add("dnwrap", 1, 0, 0,   0, 2'b00, 4,   0,  0,   4,  1, 1, 0);
        add("dn3",    1, 0, 0,   0, 2'b00, 4,   0,  0,   3,  0, 1, 0);
        add("l0ld",   1, 1, 0,   1, 2'b00, 0,   0,  0,   0,  0, 1, 0);
        add("l0wrap", 1, 0, 0,   1, 2'b00, 0,   0,  0,   0,  1, 1, 0);
        add("l0sat",  1, 0, 0,   0, 2'b01, 0,   0,  0,   0,  1, 1, 0);
        add("m3ld",   1, 1, 1,   1, 2'b11, 2,   0,  0,   1,  0, 1, 0);
        add("m3s2",   1, 0, 0,   1, 2'b11, 2,   0,  0,   2,  0, 1, 0);
        add("m3s0",   1, 0, 0,   1, 2'b11, 2,   0,  0,   0,  1, 1, 0);
        add("m3s1",   1, 0, 0,   1, 2'b11, 2,   0,  0,   1,  0, 1, 0);
        // Set up count 7, ovf 1, busy 1 for the reset test.
        add("rsld",   1, 1, 5,   1, 2'b10, 20,  0,  0,   5,  0, 1, 1);
        add("rs6",    1, 0, 0,   1, 2'b10, 20,  0,  0,   6,  0, 1, 1);
        add("rs7",    1, 0, 0,   1, 2'b10, 20,  0,  0,   7,  0, 1, 1);

        rst_n = 1'b0; enable = 1'b0; load = 1'b0; data = '0; up = 1'b1; mode = 2'b00;
        limit = '0; prescale = '0; clr_ovf = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en; load = vecs[i].ld; data = vecs[i].dat; up = vecs[i].up;
            mode = vecs[i].md; limit = vecs[i].lim; prescale = vecs[i].pre;
            clr_ovf = vecs[i].clr;
            @(posedge clk);
            #1;
            chk_all(vecs[i].name, vecs[i].e_count, vecs[i].e_tc, vecs[i].e_ovf, vecs[i].e_busy);
        end

        // Asynchronous reset mid-run: outputs must drop before any clock edge.
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rst_async", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("rst_held", 0, 0, 0, 0);
        #3;
        rst_n = 1'b1;
        // One-shot mode stays idle after reset, so enabled steps must not move or flag anything.
        @(posedge clk);
        #1;
        chk_all("rst_rel1", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("rst_rel2", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised, loadable up/down counter with programmable terminal limit, prescaler, and three count modes: wrap, saturate, and one-shot. It generalises the team's 8-bit load/enable counter to arbitrary width and adds direction control, terminal-count signalling and a sticky overflow flag. It is used as the timebase and event counter for lab datapaths and is driven directly by control logic in the same clock domain.

## Interface
- WIDTH, 8, counter, DATA and LIMIT width (≥2)
- PRESCALE_W, 4, prescaler compare width (≥1)

- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous active-low reset
- ENABLE  in  1  counting enable (gates prescaler and steps)
- LOAD  in  1  synchronous load of DATA, independent of ENABLE
- DATA  in  WIDTH  load value
- UP  in  1  1 = count up, 0 = count down
- MODE  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- LIMIT  in  WIDTH  upper boundary value
- PRESCALE  in  PRESCALE_W  step every PRESCALE+1 enabled cycles
- CLR_OVF  in  1  clear sticky OVF
- COUNT  out  WIDTH  current count
- TC  out  1  one-cycle terminal-count pulse
- OVF  out  1  sticky boundary-event flag
- BUSY  out  1  one-shot run in progress

## Operation
- Priority: RST > LOAD > step > hold.
- Prescaler: internal counter P. When ENABLE=1 and P==PRESCALE, a step is issued and P→0; otherwise, when ENABLE=1, P increments. When ENABLE=0, P holds. LOAD clears P. PRESCALE=0 issues a step on every enabled cycle.
- Boundary: up is COUNT ≥ LIMIT; down is COUNT == 0. A step taken while at the boundary is a boundary event.
- Wrap mode: up at boundary → 0; down at boundary → LIMIT; otherwise ±1.
- Saturate mode: at boundary COUNT holds; otherwise ±1.
- One-shot mode, FSM IDLE/RUN/DONE:
  - Reset → IDLE.
  - LOAD with MODE=10 → RUN.
  - In RUN, steps act ±1. A boundary event holds COUNT and moves the FSM → DONE.
  - In IDLE and DONE, steps are ignored.
  - If MODE≠10, the FSM → IDLE.
  - BUSY = (state==RUN).
- A boundary event, in any mode, sets TC for the next cycle only and sets OVF.
- OVF clears on CLR_OVF. If a set and CLR_OVF occur in the same cycle, the set wins.
- Arithmetic is modulo 2^WIDTH, but boundaries prevent wrap past 0 or LIMIT.
- DATA > LIMIT loads as-is. The next up step is a boundary event.
- LIMIT=0: wrap and saturate modes hold COUNT at 0, and every step is a boundary event.
- LOAD has no boundary check and generates no TC.

## Timing
- Reset values: COUNT=0, TC=0, OVF=0, BUSY=0, P=0, FSM=IDLE. Reset applies asynchronously on the RST falling edge and releases synchronously to CLK.
- LOAD: COUNT=DATA at the next edge. BUSY rises at that same edge in one-shot mode.
- Step: COUNT changes at the edge where the step condition is sampled. The first step occurs PRESCALE+1 enabled cycles after a load or after P=0.
- TC is high during the cycle after the edge that performed the boundary event. Back-to-back events give TC high on consecutive cycles.
- LOAD coincident with a would-be step: LOAD wins, there is no TC, and P→0.
- MODE, UP and LIMIT are sampled each edge. Changing them mid-count takes effect at the next step.
- RST asserted mid-run: all state returns to reset values immediately. There is no step or TC on the release edge.

## Test plan
- Reset, then WIDTH=8, MODE=00, UP=1, LIMIT=5, PRESCALE=0, ENABLE=1 → COUNT 0,1,2,3,4,5,0. TC is high one cycle after the 5→0 edge and OVF=1.
- MODE=01, UP=0, LOAD DATA=2, ENABLE=1 → COUNT 2,1,0,0,0. TC pulses on each cycle following a step at 0. CLR_OVF and a set in the same cycle leave OVF=1.
- MODE=10, UP=1, LIMIT=3, LOAD DATA=0 → BUSY=1 and COUNT 0,1,2,3. BUSY falls when a step is taken at 3, one TC follows, and COUNT holds at 3. A further LOAD DATA=1 rearms the counter with BUSY=1.
- PRESCALE=3, MODE=00, UP=1 → COUNT increments every 4 enabled cycles. ENABLE=0 for 2 cycles stretches that interval by 2. LOAD clears the prescaler.
- LIMIT=4, LOAD DATA=200, UP=1 → the next step gives COUNT=0 with TC. Then UP=0, step → COUNT=4 with TC.
- Assert RST mid-count at COUNT=7 with OVF=1 and BUSY=1 → all outputs are 0 before the next CLK edge. There is no TC after release.
